micro_sequencer: RTL
====================

# micro_sequencer

Microprogram sequencer that consumes the instruction decoder's branch addresses and walks the control store. It accepts a 16-bit instruction from fetch through a valid/ready handshake and latches it into `ir`, which feeds the decoder. The decoder combinationally returns the instruction-branch address `ib` and the sequence-branch address `sb`. The sequencer then steps the 5-bit micro-PC `upc` under control of the current microword's sequencing field, including dispatch, conditional branch and micro-subroutine call/return, until an end-of-instruction microword returns it to fetch.

## Interface
- `ENTRY`, default 5'd1: micro-address loaded into `upc` when an instruction is accepted.
- `STACK_DEPTH`, default 4: micro-return stack entries, 1..8.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: reset; synchronous, active-high.
- `ins_in` input, 16 bits: instruction word from fetch.
- `ins_valid` input, 1 bit: `ins_in` is valid.
- `ins_ready` output, 1 bit: sequencer will accept `ins_in` this cycle.
- `ir` output, 16 bits: latched instruction, drives the decoder's `ins`.
- `ib` input, 5 bits: instruction-branch address from the decoder, combinational off `ir`.
- `sb` input, 5 bits: sequence-branch address from the decoder, combinational off `ir`.
- `mw_seq` input, 3 bits: sequencing op of the microword at `upc` (asynchronous control store).
- `mw_addr` input, 5 bits: branch target field of the microword at `upc`.
- `zf` input, 1 bit: ALU zero flag, sampled on BZ.
- `stall` input, 1 bit: freezes all sequencer state.
- `upc` output, 5 bits: micro-PC, addresses the control store.
- `busy` output, 1 bit: high in EXEC.
- `err` output, 1 bit: sticky stack fault.

## Operation
- States:
  - WAIT: idle, awaiting an instruction.
  - EXEC: stepping microcode.
  - ERR: fault; exited only by `rst`.
- `ins_ready = (state==WAIT) & ~stall & ~rst`, combinational.
- WAIT:
  - On `ins_valid & ins_ready`: `ir <= ins_in`, `upc <= ENTRY`, state goes to EXEC.
  - Otherwise all registers hold.
- EXEC with `stall=1`: `upc`, stack, stack pointer and state all hold; `mw_seq` is ignored.
- EXEC with `stall=0`, action by `mw_seq`:
  - 000 NEXT: `upc <= upc+1`, modulo 32 (31 wraps to 0).
  - 001 JMP: `upc <= mw_addr`.
  - 010 DISP_IB: `upc <= ib`.
  - 011 DISP_SB: `upc <= sb`.
  - 100 BZ: `upc <= zf ? mw_addr : upc+1`.
  - 101 CALL:
    - Stack not full: push `upc+1` (mod 32), then `upc <= mw_addr`.
    - Stack full: go to ERR, `upc` holds.
  - 110 RET:
    - Stack not empty: `upc <=` popped value.
    - Stack empty: go to ERR, `upc` holds.
  - 111 FETCH: state goes to WAIT, `upc` holds, stack pointer clears to 0.
- Stack is LIFO, pointer ranges 0..STACK_DEPTH. Entry contents need not clear on FETCH or rst.
- `ir` changes only on an accepted handshake; it is stable for the whole EXEC period.
- ERR: `err=1`, `busy=0`, `ins_ready=0`. All inputs are ignored until `rst`.
- `ins_valid` outside WAIT is ignored; no instruction is lost because `ins_ready` is 0.

## Timing
- Reset, on a clock edge with `rst=1`: state WAIT, `upc=0`, `ir=0`, stack pointer 0, `err=0`, `busy=0`. `ins_ready` is 0 while `rst` is high.
- `rst` mid-EXEC or in ERR aborts at the next edge; no stack or ir contents are retained as architectural state.
- Accept-to-dispatch:
  - Handshake at edge N loads `ir` and `upc=ENTRY`.
  - `ib`/`sb` are valid combinationally after edge N.
  - A DISP_IB microword at ENTRY loads `upc=ib` at edge N+1.
- One `upc` update per non-stalled EXEC cycle; every op has a latency of 1 cycle.
- FETCH at edge M:
  - `ins_ready` rises after M.
  - Earliest next accept is at edge M+1.
  - Minimum instruction occupancy is 2 cycles (ENTRY microword = FETCH).
- `stall` asserted at the same cycle as a handshake blocks the handshake.
- `zf` is sampled only at the BZ edge; no registering.

## Test plan
- Reset/accept:
  - Stimulus: hold `rst` 2 cycles; `ins_valid=1`, `ins_in=16'h0010`.
  - Required: `ins_ready=0` during reset, `upc=0`, `ir=0`. After reset, accepted at the first edge: `ir=16'h0010`, `upc=1`, `busy=1`, `ins_ready=0`.
- Dispatch chain:
  - Stimulus: `ib=5'b00101`; microword at 1 = DISP_IB; at 5 = DISP_SB with `sb=5'b01101`; at 13 = FETCH.
  - Required: `upc` sequence 1, 5, 13, then WAIT with `ins_ready=1`.
- BZ and wrap:
  - Stimulus: BZ at `upc=3`, `mw_addr=20`, `zf=1`; then rerun with `zf=0`. Separately, NEXT at `upc=31`.
  - Required: `upc=20` when `zf=1`; `upc=4` when `zf=0`; NEXT at 31 gives `upc=0`.
- Call/return nest:
  - Stimulus: CALL at 2 to 10; CALL at 10 to 20; RET; RET.
  - Required: `upc` sequence 10, 20, 11, 3; `err` stays 0.
- Stack faults:
  - Stimulus: STACK_DEPTH+1 nested CALLs. Separately, from reset, a RET.
  - Required: `err=1` with `upc` frozen at the faulting address; `ins_ready=0`. `rst` clears `err`.
- Stall:
  - Stimulus: `stall=1` for 3 cycles during a CALL microword. Separately, `stall=1` in WAIT with `ins_valid=1`.
  - Required: during the CALL stall, `upc` and stack are unchanged; the call completes on the first unstalled edge. In WAIT, `ins_ready=0` and `ir` is unchanged.

Source files
------------

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer with dispatch, branch and micro-subroutine stack
module micro_sequencer #(
    parameter logic [4:0] ENTRY       = 5'd1,
    parameter int         STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ins_in,
    input  logic        ins_valid,
    output logic        ins_ready,
    output logic [15:0] ir,
    input  logic [4:0]  ib,
    input  logic [4:0]  sb,
    input  logic [2:0]  mw_seq,
    input  logic [4:0]  mw_addr,
    input  logic        zf,
    input  logic        stall,
    output logic [4:0]  upc,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_EXEC,
        S_ERR
    } state_t;

    localparam logic [2:0] OP_NEXT    = 3'd0;
    localparam logic [2:0] OP_JMP     = 3'd1;
    localparam logic [2:0] OP_DISP_IB = 3'd2;
    localparam logic [2:0] OP_DISP_SB = 3'd3;
    localparam logic [2:0] OP_BZ      = 3'd4;
    localparam logic [2:0] OP_CALL    = 3'd5;
    localparam logic [2:0] OP_RET     = 3'd6;
    localparam logic [2:0] OP_FETCH   = 3'd7;

    state_t      state;
    logic [3:0]  sp;
    // Storage is sized for the largest legal depth so indices stay 3 bits wide.
    logic [4:0]  stack [0:7];
    logic [4:0]  upc_inc;
    logic [2:0]  top_idx;
    logic        full;
    logic        empty;
    logic        run;

    assign upc_inc   = upc + 5'd1;
    assign top_idx   = sp[2:0] - 3'd1;
    assign full      = (sp == 4'(STACK_DEPTH));
    assign empty     = (sp == 4'd0);
    assign run       = (state == S_EXEC) && !stall;
    assign ins_ready = (state == S_WAIT) && !stall && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
            upc   <= 5'd0;
            ir    <= 16'd0;
            sp    <= 4'd0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (ins_valid && !stall) begin
                        ir    <= ins_in;
                        upc   <= ENTRY;
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        case (mw_seq)
                            OP_NEXT:    upc <= upc_inc;
                            OP_JMP:     upc <= mw_addr;
                            OP_DISP_IB: upc <= ib;
                            OP_DISP_SB: upc <= sb;
                            OP_BZ:      upc <= zf ? mw_addr : upc_inc;
                            OP_CALL: begin
                                if (full) begin
                                    state <= S_ERR;
                                    busy  <= 1'b0;
                                    err   <= 1'b1;
                                end else begin
                                    sp  <= sp + 4'd1;
                                    upc <= mw_addr;
                                end
                            end
                            OP_RET: begin
                                if (empty) begin
                                    state <= S_ERR;
                                    busy  <= 1'b0;
                                    err   <= 1'b1;
                                end else begin
                                    sp  <= sp - 4'd1;
                                    upc <= stack[top_idx];
                                end
                            end
                            OP_FETCH: begin
                                state <= S_WAIT;
                                busy  <= 1'b0;
                                sp    <= 4'd0;
                            end
                        endcase
                    end
                end
                S_ERR: ;
                default: begin
                    state <= S_ERR;
                    busy  <= 1'b0;
                    err   <= 1'b1;
                end
            endcase
        end
    end

    // Entry contents carry no reset; only the pointer is architectural.
    always_ff @(posedge clk) begin
        if (!rst && run && (mw_seq == OP_CALL) && !full) begin
            stack[sp[2:0]] <= upc_inc;
        end
    end

endmodule
